axi_rr_arbiter: RTL and testbench

AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

---
 rtl/axi_rr_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// Grant arbiter placing NUM_M AXI masters onto one slave port.
// Write and read channels are arbitrated by independent FSMs.
// A grant is held from acceptance until its transaction completes.
// Selection is round-robin (ARB_MODE=0) or fixed priority, lowest index first (ARB_MODE=1).
//
// Handshake semantics: a transfer on any channel happens in a cycle where
// the sender's valid and the receiver's ready are both high at the rising
// edge of aclk. Only the granted master's valid/ready bits are examined;
// the bits of all other masters are masked off by the one-hot grant.
module axi_rr_arbiter #(
  parameter int NUM_M    = 3,
  parameter int ARB_MODE = 0,
  parameter int IDX_W    = 2
) (
  input  logic             aclk,
  input  logic             rst_n,
  input  logic [NUM_M-1:0] m_awvalid,
  input  logic [NUM_M-1:0] m_wvalid,
  input  logic [NUM_M-1:0] m_wlast,
  input  logic [NUM_M-1:0] m_bready,
  input  logic [NUM_M-1:0] m_arvalid,
  input  logic [NUM_M-1:0] m_rready,
  input  logic             s_awready,
  input  logic             s_wready,
  input  logic             s_bvalid,
  input  logic             s_arready,
  input  logic             s_rvalid,
  input  logic             s_rlast,
  output logic [NUM_M-1:0] grant_w,
  output logic [NUM_M-1:0] grant_r,
  output logic [IDX_W-1:0] grant_w_idx,
  output logic [IDX_W-1:0] grant_r_idx,
  output logic             busy_w,
  output logic             busy_r,
  output logic [1:0]       w_state_dbg,
  output logic [1:0]       r_state_dbg
);

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_M - 1);

  // Winner search: round-robin starts one past the last winner and wraps;
  // fixed priority always starts at index 0 and ignores the pointer.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_M-1:0] req,
                                                   input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] win;
    logic             found;
    int               cand;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      cand = (ARB_MODE != 0) ? i : ((int'(last) + 1 + i) % NUM_M);
      if (!found && (|(req & (NUM_M'(1) << cand)))) begin
        win   = IDX_W'(cand);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  w_state_t         w_state, w_state_n;
  r_state_t         r_state, r_state_n;
  logic [NUM_M-1:0] grant_w_n, grant_r_n;
  logic [IDX_W-1:0] grant_w_idx_n, grant_r_idx_n;
  logic [IDX_W-1:0] w_ptr, w_ptr_n, r_ptr, r_ptr_n;
  logic             aw_done, aw_done_n, w_done, w_done_n;
  logic [IDX_W-1:0] w_win, r_win;
  logic             aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  assign w_win = pick_winner(m_awvalid, w_ptr);
  assign r_win = pick_winner(m_arvalid, r_ptr);

  // Handshakes of the granted master only.
  assign aw_hs     = (|(m_awvalid & grant_w)) & s_awready;
  assign w_last_hs = (|(m_wvalid & m_wlast & grant_w)) & s_wready;
  assign b_hs      = (|(m_bready & grant_w)) & s_bvalid;
  assign ar_hs     = (|(m_arvalid & grant_r)) & s_arready;
  assign r_last_hs = (|(m_rready & grant_r)) & s_rvalid & s_rlast;

  assign busy_w      = (w_state != W_IDLE);
  assign busy_r      = (r_state != R_IDLE);
  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

  // Write channel state, grant, completion flags and last-winner pointer.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      w_state     <= W_IDLE;
      grant_w     <= '0;
      grant_w_idx <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      w_ptr       <= PTR_RESET;
    end else begin
      w_state     <= w_state_n;
      grant_w     <= grant_w_n;
      grant_w_idx <= grant_w_idx_n;
      aw_done     <= aw_done_n;
      w_done      <= w_done_n;
      w_ptr       <= w_ptr_n;
    end
  end

  // Write next state: arbitrate in idle, collect AW and last-W, then wait for B.
  always_comb begin
    w_state_n     = w_state;
    grant_w_n     = grant_w;
    grant_w_idx_n = grant_w_idx;
    aw_done_n     = aw_done;
    w_done_n      = w_done;
    w_ptr_n       = w_ptr;
    case (w_state)
      W_IDLE: begin
        if (|m_awvalid) begin
          grant_w_n     = NUM_M'(1) << w_win;
          grant_w_idx_n = w_win;
          w_state_n     = W_XFER;
        end
      end
      W_XFER: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_last_hs;
        if (aw_done_n && w_done_n) w_state_n = W_RESP;
      end
      W_RESP: begin
        if (b_hs) begin
          grant_w_n     = '0;
          grant_w_idx_n = '0;
          aw_done_n     = 1'b0;
          w_done_n      = 1'b0;
          w_ptr_n       = grant_w_idx;
          w_state_n     = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read channel state, grant and last-winner pointer.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= R_IDLE;
      grant_r     <= '0;
      grant_r_idx <= '0;
      r_ptr       <= PTR_RESET;
    end else begin
      r_state     <= r_state_n;
      grant_r     <= grant_r_n;
      grant_r_idx <= grant_r_idx_n;
      r_ptr       <= r_ptr_n;
    end
  end

  // Read next state: arbitrate in idle, address handshake, then data until rlast.
  always_comb begin
    r_state_n     = r_state;
    grant_r_n     = grant_r;
    grant_r_idx_n = grant_r_idx;
    r_ptr_n       = r_ptr;
    case (r_state)
      R_IDLE: begin
        if (|m_arvalid) begin
          grant_r_n     = NUM_M'(1) << r_win;
          grant_r_idx_n = r_win;
          r_state_n     = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ar_hs) r_state_n = R_DATA;
      end
      R_DATA: begin
        if (r_last_hs) begin
          grant_r_n     = '0;
          grant_r_idx_n = '0;
          r_ptr_n       = grant_r_idx;
          r_state_n     = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: directed scenarios plus randomized transactions,
// one round-robin instance and one fixed-priority instance on shared inputs.
module tb_axi_rr_arbiter;
  localparam int N  = 3;
  localparam int IW = 2;

  // Clock / reset
  logic aclk = 1'b0;
  logic rst_n;
  always #5 aclk = ~aclk;

  logic [N-1:0] m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
  logic         s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;

  logic [N-1:0]  rr_gw, rr_gr, fp_gw, fp_gr;
  logic [IW-1:0] rr_gwi, rr_gri, fp_gwi, fp_gri;
  logic          rr_bw, rr_br, fp_bw, fp_br;
  logic [1:0]    rr_wdbg, rr_rdbg, fp_wdbg, fp_rdbg;

  int checks = 0;
  int errors = 0;
  bit use_fp = 1'b0;
  int last_w, last_r;

  // Outputs of whichever instance is under observation.
  logic [N-1:0]  obs_gw, obs_gr;
  logic [IW-1:0] obs_gwi, obs_gri;
  logic          obs_bw, obs_br;
  assign obs_gw  = use_fp ? fp_gw  : rr_gw;
  assign obs_gr  = use_fp ? fp_gr  : rr_gr;
  assign obs_gwi = use_fp ? fp_gwi : rr_gwi;
  assign obs_gri = use_fp ? fp_gri : rr_gri;
  assign obs_bw  = use_fp ? fp_bw  : rr_bw;
  assign obs_br  = use_fp ? fp_br  : rr_br;

  axi_rr_arbiter #(.NUM_M(N), .ARB_MODE(0), .IDX_W(IW)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_rready(m_rready),
    .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
    .grant_w(rr_gw), .grant_r(rr_gr), .grant_w_idx(rr_gwi), .grant_r_idx(rr_gri),
    .busy_w(rr_bw), .busy_r(rr_br), .w_state_dbg(rr_wdbg), .r_state_dbg(rr_rdbg)
  );

  axi_rr_arbiter #(.NUM_M(N), .ARB_MODE(1), .IDX_W(IW)) dut_fp (
    .aclk(aclk), .rst_n(rst_n),
    .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_rready(m_rready),
    .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
    .grant_w(fp_gw), .grant_r(fp_gr), .grant_w_idx(fp_gwi), .grant_r_idx(fp_gri),
    .busy_w(fp_bw), .busy_r(fp_br), .w_state_dbg(fp_wdbg), .r_state_dbg(fp_rdbg)
  );

  // Reference model: list the masters in search order, first requester wins.
  function automatic int pick(input logic [N-1:0] req, input int last, input bit fp);
    int order[$];
    for (int i = 0; i < N; i++) order.push_back(fp ? i : (last + 1 + i) % N);
    foreach (order[k]) if (req[order[k]]) return order[k];
    return 0;
  endfunction

  function automatic logic [N-1:0] rnd_vec();
    return N'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_w();
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
  endtask

  task automatic clear_r();
    m_arvalid = '0; m_rready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_gw"}, obs_gw, 0);
    chk({tag, "_gr"}, obs_gr, 0);
    chk({tag, "_gwi"}, obs_gwi, 0);
    chk({tag, "_gri"}, obs_gri, 0);
    chk({tag, "_busy_w"}, obs_bw, 0);
    chk({tag, "_busy_r"}, obs_br, 0);
  endtask

  task automatic do_reset();
    clear_w();
    clear_r();
    rst_n = 1'b0;
    #1;
    check_idle("reset");
    repeat (2) @(posedge aclk);
    #1;
    rst_n = 1'b1;
    last_w = N - 1;
    last_r = N - 1;
    check_idle("post_reset");
  endtask

  // One full write transaction; AW and last-W land after aw_d / w_d cycles,
  // B after b_d stall cycles. decoy drives B valid/ready during the transfer.
  task automatic write_txn(input logic [N-1:0] req, input int aw_d, input int w_d,
                           input int b_d, input bit decoy, output int got);
    int win, last_c;
    logic [N-1:0] gexp, others;
    clear_w();
    m_awvalid = req;
    tick();
    win  = pick(req, last_w, use_fp);
    gexp = N'(1) << win;
    got  = int'(obs_gwi);
    chk("w_grant", obs_gw, gexp);
    chk("w_idx", obs_gwi, win);
    chk("w_busy", obs_bw, 1);
    others = req & ~gexp;
    last_c = (aw_d > w_d) ? aw_d : w_d;
    for (int c = 0; c <= last_c; c++) begin
      m_awvalid = others;
      m_awvalid[win] = (c <= aw_d);
      s_awready = (c == aw_d) ? 1'b1 : ((c > aw_d) ? rbit() : 1'b0);
      m_wvalid = rnd_vec();
      m_wlast  = rnd_vec();
      m_wvalid[win] = (c == w_d) ? 1'b1 : rbit();
      m_wlast[win]  = (c == w_d);
      s_wready = (c == w_d) ? 1'b1 : rbit();
      s_bvalid = decoy ? 1'b1 : rbit();
      m_bready = decoy ? '1 : rnd_vec();
      tick();
      chk("w_hold_xfer", obs_gw, gexp);
      chk("w_hold_xfer_idx", obs_gwi, win);
    end
    for (int d = 0; d < b_d; d++) begin
      m_awvalid = others;
      s_awready = rbit();
      m_wvalid = rnd_vec();
      m_wlast  = rnd_vec();
      s_wready = rbit();
      s_bvalid = rbit();
      m_bready = rnd_vec();
      if (s_bvalid) m_bready[win] = 1'b0;
      tick();
      chk("w_hold_resp", obs_gw, gexp);
    end
    m_awvalid = others;
    m_bready = rnd_vec();
    m_bready[win] = 1'b1;
    s_bvalid = 1'b1;
    tick();
    chk("w_done_gw", obs_gw, 0);
    chk("w_done_idx", obs_gwi, 0);
    chk("w_done_busy", obs_bw, 0);
    last_w = win;
    clear_w();
  endtask

  // One full read transaction: AR after ar_d cycles, then `beats` data beats
  // with random stalls. decoy drives rvalid/rlast/rready during the address phase.
  task automatic read_txn(input logic [N-1:0] req, input int ar_d, input int beats,
                          input bit decoy, output int got);
    int win, stalls;
    logic [N-1:0] gexp, others;
    clear_r();
    m_arvalid = req;
    tick();
    win  = pick(req, last_r, use_fp);
    gexp = N'(1) << win;
    got  = int'(obs_gri);
    chk("r_grant", obs_gr, gexp);
    chk("r_idx", obs_gri, win);
    chk("r_busy", obs_br, 1);
    others = req & ~gexp;
    for (int c = 0; c <= ar_d; c++) begin
      m_arvalid = others;
      m_arvalid[win] = 1'b1;
      s_arready = (c == ar_d);
      s_rvalid = decoy ? 1'b1 : rbit();
      s_rlast  = decoy ? 1'b1 : rbit();
      m_rready = decoy ? '1 : rnd_vec();
      tick();
      chk("r_hold_addr", obs_gr, gexp);
    end
    m_arvalid = others;
    s_arready = 1'b0;
    for (int b = 0; b < beats; b++) begin
      stalls = $urandom_range(0, 2);
      for (int s = 0; s < stalls; s++) begin
        s_rvalid = rbit();
        s_rlast  = rbit();
        m_rready = rnd_vec();
        if (s_rvalid) m_rready[win] = 1'b0;
        tick();
        chk("r_hold_stall", obs_gr, gexp);
      end
      s_rvalid = 1'b1;
      s_rlast  = (b == beats - 1);
      m_rready = rnd_vec();
      m_rready[win] = 1'b1;
      tick();
      if (b == beats - 1) begin
        chk("r_done_gr", obs_gr, 0);
        chk("r_done_idx", obs_gri, 0);
        chk("r_done_busy", obs_br, 0);
      end else begin
        chk("r_hold_beat", obs_gr, gexp);
      end
    end
    last_r = win;
    clear_r();
  endtask

  int got;
  int exp_order[4] = '{0, 1, 2, 0};

  initial begin
    do_reset();

    // Round-robin order with all three masters requesting.
    for (int k = 0; k < 4; k++) begin
      write_txn(3'b111, 1, 1, 0, 1'b0, got);
      chk("rr_order", got, exp_order[k]);
    end

    // Last W two cycles ahead of AW; B offered early must not complete.
    write_txn(3'b001, 2, 0, 1, 1'b1, got);
    chk("w_before_aw_win", got, 0);

    // AW and last W in the same cycle, B three cycles later.
    write_txn(3'b010, 1, 1, 3, 1'b1, got);
    chk("aw_w_same_win", got, 1);

    // Concurrent write (master 0) and 4-beat read (master 1).
    clear_w(); clear_r();
    m_awvalid = 3'b001; m_arvalid = 3'b010;
    tick();
    chk("cc_gw", obs_gw, 3'b001);
    chk("cc_gr", obs_gr, 3'b010);
    m_awvalid = 3'b001; s_awready = 1'b1; m_wvalid = 3'b001; m_wlast = 3'b001; s_wready = 1'b1;
    m_arvalid = 3'b010; s_arready = 1'b1;
    tick();
    chk("cc_gw_hold", obs_gw, 3'b001);
    chk("cc_gr_hold", obs_gr, 3'b010);
    clear_w(); clear_r();
    s_bvalid = 1'b1; m_bready = 3'b001;
    s_rvalid = 1'b1; m_rready = 3'b010; s_rlast = 1'b0;
    tick();
    chk("cc_gw_done", obs_gw, 0);
    chk("cc_gr_beat1", obs_gr, 3'b010);
    clear_w();
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 3'b101;
    tick();
    chk("cc_gr_foreign_rready", obs_gr, 3'b010);
    s_rlast = 1'b0; m_rready = 3'b010;
    tick();
    chk("cc_gr_beat2", obs_gr, 3'b010);
    tick();
    chk("cc_gr_beat3", obs_gr, 3'b010);
    s_rlast = 1'b1;
    tick();
    chk("cc_gr_rlast", obs_gr, 0);
    chk("cc_busy_r", obs_br, 0);
    clear_r();
    last_w = 0;
    last_r = 1;

    // Reset pulsed mid-transfer clears outputs without waiting for a clock.
    m_awvalid = 3'b011; m_arvalid = 3'b100;
    tick();
    chk("ar_pre_gw", obs_gw, N'(1) << pick(3'b011, last_w, 1'b0));
    chk("ar_pre_gr", obs_gr, 3'b100);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    clear_w(); clear_r();
    @(posedge aclk);
    #1;
    rst_n = 1'b1;
    last_w = N - 1;
    last_r = N - 1;
    write_txn(3'b110, 0, 1, 0, 1'b0, got);
    chk("post_rst_w_first", got, 1);
    read_txn(3'b110, 0, 1, 1'b0, got);
    chk("post_rst_r_first", got, 1);

    // Randomized round-robin traffic.
    for (int t = 0; t < 25; t++)
      write_txn(N'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), rbit(), got);
    for (int t = 0; t < 25; t++)
      read_txn(N'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(1, 4),
               rbit(), got);

    // Fixed-priority instance.
    use_fp = 1'b1;
    do_reset();
    read_txn(3'b110, 0, 2, 1'b0, got);
    chk("fp_first", got, 1);
    for (int k = 0; k < 3; k++) begin
      read_txn(3'b111, $urandom_range(0, 2), $urandom_range(1, 3), 1'b0, got);
      chk("fp_repeat", got, 0);
    end
    for (int t = 0; t < 12; t++)
      read_txn(N'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(1, 4),
               rbit(), got);
    for (int t = 0; t < 12; t++)
      write_txn(N'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), rbit(), got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a grant never completes.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
